// File: rtl/rom_checksum_pkg.sv
// Shared types and constants for the ROM checksum scanner.
package rom_checksum_pkg;
  localparam int CSUM_W = 16;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/rom_checksum.sv
// Boot-time ROM scanner: sums SIZE bytes modulo 2^16 through a two-stage pipeline.
// Optional ROM_CHECKSUM_AUTOSTART_EN: scan automatically after reset, keep the CPU held on a bad ROM.
module rom_checksum
  import rom_checksum_pkg::*;
#(
  parameter int                  SIZE     = 8192,
  parameter logic [CSUM_W-1:0]   EXPECTED = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [ADDR_W-1:0]   ROM_ADDRESS,
  output logic                rom_output_enable,
  input  logic [7:0]          ROM_DATA,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CSUM_W-1:0]   CHECKSUM,
  output logic                cpu_hold
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_oe;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [CSUM_W-1:0]   r_csum;
  logic [CSUM_W-1:0]   r_acc;
  logic [7:0]          r_data;
  logic                r_valid;
  logic [CSUM_W-1:0]   w_final;
  logic                w_start;

  // Accumulator plus the byte waiting in the data stage; carries past bit 15 drop out.
  assign w_final = r_acc + CSUM_W'(r_data);

`ifdef ROM_CHECKSUM_AUTOSTART_EN
  logic r_auto;
  logic r_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_auto <= 1'b1;
      r_hold <= 1'b1;
    end else begin
      r_auto <= 1'b0;
      if (r_state == DRAIN) r_hold <= (w_final != EXPECTED);
    end
  end

  assign w_start  = start | r_auto;
  assign cpu_hold = r_busy | r_hold;
`else
  assign w_start  = start;
  assign cpu_hold = r_busy;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_csum  <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state <= RUN;
            r_addr  <= '0;
            r_oe    <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_csum  <= '0;
            r_acc   <= '0;
          end
        end
        RUN: begin
          r_data  <= ROM_DATA;
          r_valid <= 1'b1;
          if (r_valid) r_acc <= w_final;
          if (r_addr == LAST_ADDR) begin
            r_state <= DRAIN;
            r_addr  <= '0;
            r_oe    <= 1'b0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Last byte is still in the data stage; fold it in as the result is published.
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_acc   <= w_final;
          r_csum  <= w_final;
          r_pass  <= (w_final == EXPECTED);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ROM_ADDRESS       = r_addr;
  assign rom_output_enable = r_oe;
  assign busy              = r_busy;
  assign done              = r_done;
  assign pass              = r_pass;
  assign CHECKSUM          = r_csum;

endmodule

// File: doc/rom_checksum.md
ROM_CHECKSUM -- requirements
Module: rom_checksum

Interface
REQ-001 SHALL have parameter SIZE, default 8192, meaning the number of ROM bytes scanned (addresses 0..SIZE-1, max 32768).
REQ-002 SHALL have parameter EXPECTED, default 16'h0000, meaning the reference checksum that PASS compares against.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: scan request, sampled on the rising edge.
REQ-006 SHALL have port ROM_ADDRESS, output, 15 bits: address driven to the ROM.
REQ-007 SHALL have port rom_output_enable, output, 1 bit: ROM read enable.
REQ-008 SHALL have port ROM_DATA, input, 8 bits: ROM read data, combinational from ROM_ADDRESS.
REQ-009 SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-010 SHALL have port done, output, 1 bit: sticky completion flag.
REQ-011 SHALL have port pass, output, 1 bit: CHECKSUM==EXPECTED, valid only while done is high.
REQ-012 SHALL have port CHECKSUM, output, 16 bits: scan result.
REQ-013 SHALL have port cpu_hold, output, 1 bit: holds the 6502 off the bus while high.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-015 SHALL make these transitions: IDLE->RUN on start; RUN->DRAIN after address SIZE-1 is issued; DRAIN->DONE unconditionally; DONE->RUN on start.
REQ-016 SHALL, in RUN, drive ROM_ADDRESS = scan counter (0 to SIZE-1, one address per cycle) with rom_output_enable=1.
REQ-017 SHALL, in every other state, drive ROM_ADDRESS=0 and rom_output_enable=0.
REQ-018 SHALL register ROM_DATA into a data stage on each RUN cycle and add it into the accumulator on the following edge, forming a two-stage pipeline.
REQ-019 SHALL compute the checksum as the sum of the zero-extended bytes, truncated modulo 2^16; carries beyond bit 15 are discarded.
REQ-020 SHALL assert done SIZE+1 cycles after the edge that samples start.
REQ-021 SHALL update CHECKSUM and pass in the same cycle that done rises, and hold them until the next scan starts or reset.
REQ-022 SHALL hold busy high in RUN and DRAIN, and low otherwise.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL, on start in DONE, clear done, pass and the accumulator, and restart the scan at address 0.
REQ-025 SHALL keep the address counter 15 bits wide and never issue an address >= SIZE, with no wrap past SIZE-1.
REQ-026 SHALL, when SIZE=1, complete the RUN state in a single cycle.
REQ-027 SHALL drive cpu_hold high while busy is high.

Reset
REQ-028 SHALL, while reset is high, force state=IDLE, scan counter=0, accumulator=0, CHECKSUM=0, busy=0, done=0, pass=0, ROM_ADDRESS=0, rom_output_enable=0.
REQ-029 SHALL, on reset during RUN or DRAIN, abort the scan and return to IDLE on the next edge with no partial result retained.
REQ-030 SHALL give reset priority over start in the same cycle.

Configuration
REQ-031 SHALL use the macro ROM_CHECKSUM_AUTOSTART_EN to select automatic start.
REQ-032 SHALL, when ROM_CHECKSUM_AUTOSTART_EN is defined, start a scan on the first edge after reset deasserts without start, and hold cpu_hold high from reset until the first done.
REQ-033 SHALL, when ROM_CHECKSUM_AUTOSTART_EN is defined, hold cpu_hold high after the first done if pass=0, so the CPU stays halted on a bad ROM.
REQ-034 SHALL, when ROM_CHECKSUM_AUTOSTART_EN is undefined, start scans only on start, drive cpu_hold equal to busy, and add no autostart logic.

Structure
REQ-035 SHALL place the FSM state enum and the constant CSUM_W=16 in shared package rom_checksum_pkg.
REQ-036 SHALL be implemented as a single module with no sub-module; counter, pipeline and FSM are local.

Verification
REQ-037 SHALL verify: ROM all 8'h01, SIZE=8192, start pulse -> done after 8193 cycles, CHECKSUM=16'h2000.
REQ-038 SHALL verify: ROM all 8'hFF, SIZE=8192 -> CHECKSUM=16'hE000 (modulo wrap); EXPECTED=16'hE000 -> pass=1; EXPECTED=16'h0000 -> pass=0.
REQ-039 SHALL verify: ROM[i]=i[7:0], SIZE=8192 -> CHECKSUM=16'hF000, ROM_ADDRESS sequence 0..8191, each issued exactly once.
REQ-040 SHALL verify: reset asserted at scan cycle 100 -> next cycle IDLE, all outputs at reset values; a fresh start then gives the full correct checksum.
REQ-041 SHALL verify: start re-pulsed mid-scan -> no effect, done at the original cycle; start in DONE -> done drops, a new scan runs, CHECKSUM is identical.
REQ-042 SHALL verify, with ROM_CHECKSUM_AUTOSTART_EN: reset release -> scan starts with no start pulse; cpu_hold stays 1 until done when pass=1, and stays 1 permanently when pass=0.
